serial_frame_rx: RTL and testbench

- Receive side of the team's single-wire serial link: deserializes start/data/stop framed bits into parallel words.
- Presents each word on a valid/ready output port.
- Sits after the link's shift-register stages and feeds parallel consumers (register files, FIFOs).
- Flags framing errors and output overruns.

---
 rtl/serial_frame_rx.sv | 109 ++++++++++
 tb/tb_serial_frame_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Receive side of the single-wire serial link: turns start/data/stop framed bits
// into parallel words on a valid/ready port, flagging framing errors and overruns.
module serial_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] shift, shift_next;
  logic [WIDTH-1:0] data_next;
  logic             valid_next;
  logic             err_next;
  logic             ovr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shift     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      shift     <= shift_next;
      out_data  <= data_next;
      out_valid <= valid_next;
      frame_err <= err_next;
      overrun   <= ovr_next;
    end
  end

  // A delivery in the stop-bit cycle overrides a concurrent handshake.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_next = shift;
    data_next  = out_data;
    valid_next = out_valid;
    err_next   = 1'b0;
    ovr_next   = 1'b0;

    if (out_valid && out_ready) begin
      valid_next = 1'b0;
    end

    if (bit_en) begin
      case (state)
        IDLE: begin
          if (!in) begin
            state_next = DATA;
            cnt_next   = '0;
          end
        end
        DATA: begin
          shift_next[cnt] = in;
          if (cnt == CW'(WIDTH - 1)) begin
            state_next = STOP;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        STOP: begin
          if (in) begin
            state_next = IDLE;
            if (!out_valid || out_ready) begin
              data_next  = shift;
              valid_next = 1'b1;
            end else begin
              ovr_next = 1'b1;
            end
          end else begin
            err_next   = 1'b1;
            state_next = BREAK;
          end
        end
        BREAK: begin
          // A held-low line is a break, never a start bit.
          if (in) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed testbench for serial_frame_rx: frames are driven bit by bit and the
// parallel outputs are compared against hand-computed words and pulses.
module tb_serial_frame_rx;

  logic       clk;
  logic       rst_n;
  logic       in;
  logic       bit_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int errCount = 0;
  int ovrCount = 0;
  logic [7:0] accepted[$];
  logic [7:0] expWords[7] = '{8'hA5, 8'hA5, 8'h81, 8'h11, 8'h11, 8'h22, 8'h0F};

  serial_frame_rx #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .bit_en    (bit_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumed words and error pulses are logged mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) accepted.push_back(out_data);
      if (frame_err) errCount++;
      if (overrun) ovrCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one link bit, preceded by gap cycles with bit_en low.
  task automatic applyStimulus(input logic b, input int gap);
    repeat (gap) begin
      in     = b;
      bit_en = 1'b0;
      tick();
    end
    in     = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
  endtask

  task automatic sendData(input logic [7:0] d, input int gap);
    applyStimulus(1'b0, gap);
    for (int i = 0; i < 8; i++) applyStimulus(d[i], gap);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopBit, input int gap);
    sendData(d, gap);
    applyStimulus(stopBit, gap);
  endtask

  initial begin
    rst_n     = 1'b0;
    in        = 1'b1;
    bit_en    = 1'b0;
    out_ready = 1'b1;
    #2;
    checkOutput("reset_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_data", {24'b0, out_data}, 32'd0);
    checkOutput("reset_flags", {30'b0, frame_err, overrun}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Basic frame, bit_en every cycle.
    sendFrame(8'hA5, 1'b1, 0);
    checkOutput("a5_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("a5_data", {24'b0, out_data}, 32'hA5);
    checkOutput("a5_flags", {30'b0, frame_err, overrun}, 32'd0);
    tick();
    checkOutput("a5_consumed", {31'b0, out_valid}, 32'd0);

    // Same frame with bit_en every third cycle.
    sendData(8'hA5, 2);
    checkOutput("gap_no_early_valid", {31'b0, out_valid}, 32'd0);
    applyStimulus(1'b1, 2);
    checkOutput("gap_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("gap_data", {24'b0, out_data}, 32'hA5);
    tick();

    // Framing error, held-low break, recovery.
    sendFrame(8'h3C, 1'b0, 0);
    checkOutput("ferr_pulse", {31'b0, frame_err}, 32'd1);
    checkOutput("ferr_no_valid", {31'b0, out_valid}, 32'd0);
    applyStimulus(1'b0, 0);
    checkOutput("ferr_one_cycle", {31'b0, frame_err}, 32'd0);
    repeat (3) applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 0);
    sendFrame(8'h81, 1'b1, 0);
    checkOutput("after_break_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("after_break_data", {24'b0, out_data}, 32'h81);
    tick();

    // Overrun with consumer stalled.
    out_ready = 1'b0;
    sendFrame(8'h11, 1'b1, 0);
    checkOutput("ovr_first_data", {24'b0, out_data}, 32'h11);
    sendFrame(8'h22, 1'b1, 0);
    checkOutput("ovr_pulse", {31'b0, overrun}, 32'd1);
    checkOutput("ovr_held_data", {24'b0, out_data}, 32'h11);
    checkOutput("ovr_held_valid", {31'b0, out_valid}, 32'd1);
    tick();
    checkOutput("ovr_one_cycle", {31'b0, overrun}, 32'd0);
    out_ready = 1'b1;
    tick();
    checkOutput("ovr_drained", {31'b0, out_valid}, 32'd0);
    checkOutput("ovr_data_kept", {24'b0, out_data}, 32'h11);

    // Handshake and delivery in the same stop-bit cycle.
    out_ready = 1'b0;
    sendFrame(8'h11, 1'b1, 0);
    sendData(8'h22, 0);
    out_ready = 1'b1;
    applyStimulus(1'b1, 0);
    checkOutput("simul_no_ovr", {31'b0, overrun}, 32'd0);
    checkOutput("simul_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("simul_data", {24'b0, out_data}, 32'h22);
    tick();

    // Reset in the middle of a frame with a word pending.
    out_ready = 1'b0;
    sendFrame(8'h55, 1'b1, 0);
    applyStimulus(1'b0, 0);
    repeat (4) applyStimulus(1'b1, 0);
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_data", {24'b0, out_data}, 32'd0);
    checkOutput("midrst_flags", {30'b0, frame_err, overrun}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    sendFrame(8'h0F, 1'b1, 0);
    checkOutput("postrst_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("postrst_data", {24'b0, out_data}, 32'h0F);
    repeat (3) tick();

    checkOutput("err_pulse_count", errCount, 32'd1);
    checkOutput("ovr_pulse_count", ovrCount, 32'd1);
    checkOutput("accepted_count", accepted.size(), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < accepted.size()) checkOutput($sformatf("accepted_%0d", i), {24'b0, accepted[i]}, {24'b0, expWords[i]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
